// File: rtl/verdict_collector.sv
// Capture sink for monitor output streams: timestamps active outputs into records,
// buffers them in a FIFO and serializes each as HDR, TS, DATA... words over valid/ready.
module verdict_collector #(
  parameter int N_OUT = 6,
  parameter int W     = 64,
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_OUT*W-1:0] out_value,
  input  logic [N_OUT-1:0]   out_aktv,
  output logic [W-1:0]       m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, TS = 2'd2, DATA = 2'd3} state_t;

  function automatic logic [7:0] popcnt(input logic [N_OUT-1:0] m);
    logic [7:0] c;
    c = 8'd0;
    for (int i = 0; i < N_OUT; i++) c = c + {7'd0, m[i]};
    return c;
  endfunction

  function automatic logic [W-1:0] hdr_word(input logic [N_OUT-1:0] m);
    logic [W-1:0] h;
    h = '0;
    h[W-1 -: 8] = 8'hA5;
    h[W-9 -: 8] = popcnt(m);
    h[N_OUT-1:0] = m;
    return h;
  endfunction

  // Scanning downward leaves the lane of the lowest set mask bit in r.
  function automatic logic [W-1:0] lane_sel(input logic [N_OUT*W-1:0] v, input logic [N_OUT-1:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int i = N_OUT - 1; i >= 0; i--) r = m[i] ? v[i*W +: W] : r;
    return r;
  endfunction

  logic [W-1:0]       ts_mem   [DEPTH];
  logic [N_OUT-1:0]   mask_mem [DEPTH];
  logic [N_OUT*W-1:0] val_mem  [DEPTH];

  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, rd_next_s;
  logic [CW-1:0]    count_r;
  logic [W-1:0]     ts_r;
  logic             overflow_r;
  logic [15:0]      drop_count_r;
  state_t           state_r, state_nxt_s;
  logic [N_OUT-1:0] rem_r, rem_nxt_s;
  logic [W-1:0]     m_data_r, data_nxt_s;
  logic             m_last_r, last_nxt_s, m_valid_r;

  logic             push_req_s, full_s, pop_s, push_s, drop_s, more_s;
  logic [N_OUT-1:0] head_mask_s, nxt_mask_s;

  assign push_req_s  = en && (out_aktv != '0);
  assign full_s      = (count_r == CW'(DEPTH));
  assign pop_s       = (state_r == DATA) && m_ready && (rem_r == '0);
  assign push_s      = push_req_s && (!full_s || pop_s);
  assign drop_s      = push_req_s && full_s && !pop_s;
  assign rd_next_s   = rd_ptr_r + AW'(1);
  assign more_s      = (count_r > CW'(1)) || push_s;
  assign head_mask_s = mask_mem[rd_ptr_r];
  // With a single record being popped, the following header comes from the capture in flight.
  assign nxt_mask_s  = (count_r == CW'(1)) ? out_aktv : mask_mem[rd_next_s];

  // Serializer next-state and next registered output word.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    data_nxt_s  = m_data_r;
    last_nxt_s  = m_last_r;
    case (state_r)
      IDLE: begin
        if (count_r != '0) begin
          state_nxt_s = HDR;
          data_nxt_s  = hdr_word(head_mask_s);
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HDR: begin
        if (m_ready) begin
          state_nxt_s = TS;
          data_nxt_s  = ts_mem[rd_ptr_r];
          last_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = HDR;
        end
      end
      TS: begin
        if (m_ready) begin
          state_nxt_s = DATA;
          data_nxt_s  = lane_sel(val_mem[rd_ptr_r], head_mask_s);
          rem_nxt_s   = head_mask_s & (head_mask_s - N_OUT'(1));
          last_nxt_s  = (rem_nxt_s == '0);
        end else begin
          state_nxt_s = TS;
        end
      end
      DATA: begin
        if (m_ready && (rem_r == '0)) begin
          last_nxt_s = 1'b0;
          if (more_s) begin
            state_nxt_s = HDR;
            data_nxt_s  = hdr_word(nxt_mask_s);
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (m_ready) begin
          data_nxt_s = lane_sel(val_mem[rd_ptr_r], rem_r);
          rem_nxt_s  = rem_r & (rem_r - N_OUT'(1));
          last_nxt_s = (rem_nxt_s == '0);
        end else begin
          state_nxt_s = DATA;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        last_nxt_s  = 1'b0;
      end
    endcase
  end

  // Serializer state and registered stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      rem_r     <= '0;
      m_data_r  <= '0;
      m_last_r  <= 1'b0;
      m_valid_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rem_r     <= rem_nxt_s;
      m_data_r  <= data_nxt_s;
      m_last_r  <= last_nxt_s;
      m_valid_r <= (state_nxt_s != IDLE);
    end
  end

  // FIFO pointers, occupancy, timestamp and drop accounting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      ts_r         <= '0;
      overflow_r   <= 1'b0;
      drop_count_r <= 16'd0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_next_s : rd_ptr_r;
      count_r  <= count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
      ts_r     <= en ? ts_r + W'(1) : ts_r;
      if (drop_s) begin
        overflow_r   <= 1'b1;
        drop_count_r <= (drop_count_r == 16'hFFFF) ? drop_count_r : drop_count_r + 16'd1;
      end else begin
        overflow_r   <= overflow_r;
        drop_count_r <= drop_count_r;
      end
    end
  end

  // Record storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      ts_mem[wr_ptr_r]   <= ts_r;
      mask_mem[wr_ptr_r] <= out_aktv;
      val_mem[wr_ptr_r]  <= out_value;
    end else begin
      ts_mem[wr_ptr_r]   <= ts_mem[wr_ptr_r];
    end
  end

  assign m_data     = m_data_r;
  assign m_valid    = m_valid_r;
  assign m_last     = m_last_r;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;

endmodule

// File: tb/tb_verdict_collector.sv
// Self-checking bench for verdict_collector: table-driven records plus corner-case
// sequences, all expected words held in a scoreboard queue.
module tb_verdict_collector;
  localparam int N = 6;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           m_ready = 1'b0;
  logic [N*W-1:0] out_value = '0;
  logic [N-1:0]   out_aktv = '0;
  logic [W-1:0]   m_data;
  logic           m_valid, m_last, overflow;
  logic [15:0]    drop_count;

  verdict_collector #(.N_OUT(N), .W(W), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .out_value(out_value), .out_aktv(out_aktv),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] data; logic last; } word_t;
  typedef struct { logic [N-1:0] mask; logic [N*W-1:0] vals; logic [7:0] exp_pop; } vec_t;

  word_t sb[$];
  vec_t  vecs [5];
  int checks = 0, errors = 0, frames = 0;
  logic mon_on = 1'b0;
  logic [W-1:0] ts_model;

  // Reference timestamp: independent of the DUT, follows reset and enable.
  always @(posedge clk or negedge rst)
    if (!rst) ts_model <= '0;
    else if (en) ts_model <= ts_model + 64'd1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [N-1:0] mask, input logic [N*W-1:0] vals,
                            input logic [W-1:0] ts, input logic [7:0] pop);
    word_t w;
    int last_k = 0;
    w.data = '0;
    w.data[63:56] = 8'hA5;
    w.data[55:48] = pop;
    w.data[N-1:0] = mask;
    w.last = 1'b0;
    sb.push_back(w);
    w.data = ts;
    sb.push_back(w);
    for (int k = 0; k < N; k++) if (mask[k]) last_k = k;
    for (int k = 0; k < N; k++) begin
      if (mask[k]) begin
        w.data = vals[k*W +: W];
        w.last = (k == last_k);
        sb.push_back(w);
      end
    end
  endtask

  // Called just after a posedge; the record is captured at the next posedge.
  task automatic capture(input logic [N-1:0] mask, input logic [N*W-1:0] vals,
                         input logic keep, input logic [7:0] pop);
    logic [W-1:0] t;
    en = 1'b1;
    out_aktv = mask;
    out_value = vals;
    t = ts_model;
    @(posedge clk); #1;
    out_aktv = '0;
    if (keep) push_frame(mask, vals, t, pop);
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n = 0;
    while ((sb.size() != 0 || m_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {63'd0, (sb.size() == 0 && !m_valid)}, 64'd1);
  endtask

  // Stream monitor: pops the scoreboard on handshakes, checks hold and back-to-back rules.
  initial begin
    word_t w;
    logic prev_stall, prev_last, prev_lasths;
    logic [W-1:0] prev_data;
    prev_stall = 1'b0; prev_last = 1'b0; prev_lasths = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!mon_on || !rst) begin
        prev_stall = 1'b0;
        prev_lasths = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {63'd0, m_valid}, 64'd1);
          chk("hold_data", m_data, prev_data);
          chk("hold_last", {63'd0, m_last}, {63'd0, prev_last});
        end
        if (prev_lasths && sb.size() != 0) chk("b2b_valid", {63'd0, m_valid}, 64'd1);
        if (m_valid && m_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=none", m_data);
          end else begin
            w = sb.pop_front();
            chk("word", m_data, w.data);
            chk("last", {63'd0, m_last}, {63'd0, w.last});
          end
          if (m_last) frames++;
        end
        prev_stall  = m_valid && !m_ready;
        prev_data   = m_data;
        prev_last   = m_last;
        prev_lasths = m_valid && m_ready && m_last;
      end
    end
  end

  initial begin
    logic [W-1:0] tsv;
    int n;
    vecs[0] = '{6'b100100, {64'd5, 64'd0, 64'd0, 64'd11, 64'd0, 64'd0}, 8'd2};
    vecs[1] = '{6'b111111, {64'h60, 64'h50, 64'h40, 64'h30, 64'h20, 64'hDEAD_BEEF_0000_0010}, 8'd6};
    vecs[2] = '{6'b000001, {64'h77, 64'h66, 64'h55, 64'h44, 64'h33, 64'hFFFF_FFFF_FFFF_FFFF}, 8'd1};
    vecs[3] = '{6'b100000, {64'h8000_0000_0000_0000, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5}, 8'd1};
    vecs[4] = '{6'b010101, {64'h99, 64'd13, 64'h88, 64'd9, 64'h1111, 64'd7}, 8'd3};

    #1;
    chk("rst_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_last", {63'd0, m_last}, 64'd0);
    chk("rst_data", m_data, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_drop", {48'd0, drop_count}, 64'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    mon_on = 1'b1;

    // Single record at ts=500, including first-word latency.
    n = 0;
    while (ts_model != 64'd500 && n < 600) begin @(posedge clk); #1; n++; end
    chk("reach_ts500", ts_model, 64'd500);
    capture(6'b000011, {64'd0, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1}, 1'b1, 8'd2);
    @(posedge clk); #1;
    chk("lat_valid", {63'd0, m_valid}, 64'd1);
    chk("lat_hdr", m_data, 64'hA502_0000_0000_0003);
    wait_drain(50, "single_drain");

    for (int i = 0; i < 5; i++) begin
      capture(vecs[i].mask, vecs[i].vals, 1'b1, vecs[i].exp_pop);
      wait_drain(50, "vec_drain");
    end

    // Sparse lanes with toggling backpressure.
    capture(6'b100100, {64'd5, 64'd0, 64'd0, 64'd11, 64'd0, 64'd0}, 1'b1, 8'd2);
    for (int i = 0; i < 12; i++) begin
      m_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_drain(50, "bp_drain");

    // Consecutive captures form separate records and drain without gaps.
    m_ready = 1'b0;
    capture(6'b000011, {64'd0, 64'd0, 64'd0, 64'd0, 64'd22, 64'd21}, 1'b1, 8'd2);
    capture(6'b001000, {64'd0, 64'd0, 64'd33, 64'd0, 64'd0, 64'd0}, 1'b1, 8'd1);
    capture(6'b110000, {64'd45, 64'd44, 64'd0, 64'd0, 64'd0, 64'd0}, 1'b1, 8'd2);
    m_ready = 1'b1;
    wait_drain(50, "b2b_drain");

    // Overflow: 10 captures into an 8-deep FIFO with the consumer stalled.
    m_ready = 1'b0;
    frames = 0;
    for (int i = 0; i < 10; i++) begin
      capture(6'b000001, {320'd0, 64'(100 + i)}, (i < 8), 8'd1);
      if (i == 7) begin
        chk("full_no_ovf", {63'd0, overflow}, 64'd0);
        chk("full_no_drop", {48'd0, drop_count}, 64'd0);
      end
    end
    chk("ovf_flag", {63'd0, overflow}, 64'd1);
    chk("ovf_drop", {48'd0, drop_count}, 64'd2);

    // Capture exactly when the head record's last word is accepted while full.
    m_ready = 1'b1;
    n = 0;
    while (!(m_valid && m_last) && n < 20) begin @(posedge clk); #1; n++; end
    chk("reach_last", {63'd0, m_valid && m_last}, 64'd1);
    capture(6'b000010, {256'd0, 64'd777, 64'd0}, 1'b1, 8'd1);
    chk("simul_drop", {48'd0, drop_count}, 64'd2);
    wait_drain(100, "ovf_drain");
    chk("ovf_frames", 64'(frames), 64'd9);
    chk("ovf_sticky", {63'd0, overflow}, 64'd1);

    // Reset while the TS word is on the bus.
    m_ready = 1'b0;
    tsv = ts_model;
    capture(6'b000100, {128'd0, 64'd0, 64'd42, 128'd0}, 1'b1, 8'd1);
    n = 0;
    while (!m_valid && n < 10) begin @(posedge clk); #1; n++; end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk("ts_word", m_data, tsv);
    #2;
    mon_on = 1'b0;
    rst = 1'b0;
    en = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    chk("mid_rst_last", {63'd0, m_last}, 64'd0);
    chk("mid_rst_data", m_data, 64'd0);
    chk("mid_rst_ovf", {63'd0, overflow}, 64'd0);
    chk("mid_rst_drop", {48'd0, drop_count}, 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    mon_on = 1'b1;
    m_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("no_stale", {63'd0, m_valid}, 64'd0);
    capture(6'b000001, {320'd0, 64'h1234}, 1'b1, 8'd1);
    wait_drain(50, "post_rst_drain");

    // Enable low: nothing captured, ts frozen, pending frame still drains.
    m_ready = 1'b0;
    capture(6'b001001, {128'd0, 64'd3, 64'd0, 64'd0, 64'd2}, 1'b1, 8'd2);
    en = 1'b0;
    out_aktv = 6'b111111;
    out_value = {6{64'hABCD}};
    m_ready = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    out_aktv = '0;
    chk("en0_drained", 64'(sb.size()), 64'd0);
    chk("en0_idle", {63'd0, m_valid}, 64'd0);
    capture(6'b000001, {320'd0, 64'h55}, 1'b1, 8'd1);
    wait_drain(50, "en1_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
